// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite write path and the frame-buffer reader.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    localparam logic [1:0] DIR_0   = 2'd0;
    localparam logic [1:0] DIR_90  = 2'd1;
    localparam logic [1:0] DIR_180 = 2'd2;
    localparam logic [1:0] DIR_270 = 2'd3;

    localparam logic [3:0] DEF_TRANSPARENT_IDX = 4'h0;
    localparam int         DEF_FB_W            = 320;
    localparam int         DEF_FB_H            = 240;

endpackage

// File: rtl/sprite_addr_map.sv
// Maps a destination offset (dx, dy) plus rotation to the sprite ROM address.
module sprite_addr_map
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 36,
    parameter int SPR_H  = 36,
    parameter int ROM_AW = 11,
    parameter int CW     = 6
) (
    input  logic [CW-1:0]     dx,
    input  logic [CW-1:0]     dy,
    input  logic [1:0]        dir,
    output logic [ROM_AW-1:0] rom_address
);

    logic [CW-1:0] sx;
    logic [CW-1:0] sy;

    always_comb begin
        sx = dx;
        sy = dy;
        case (dir)
            DIR_90: begin
                sx = dy;
                sy = CW'(SPR_W - 1) - dx;
            end
            DIR_180: begin
                sx = CW'(SPR_W - 1) - dx;
                sy = CW'(SPR_H - 1) - dy;
            end
            DIR_270: begin
                sx = CW'(SPR_H - 1) - dy;
                sy = dx;
            end
            default: ;
        endcase
        rom_address = ROM_AW'(32'(sy) * SPR_W + 32'(sx));
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a rotated sprite from ROM into the frame buffer, skipping transparent and off-screen pixels.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int         SPR_W           = 36,
    parameter int         SPR_H           = 36,
    parameter int         FB_W            = DEF_FB_W,
    parameter int         FB_H            = DEF_FB_H,
    parameter logic [3:0] TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
    parameter int         ROM_AW          = 11,
    parameter int         FB_AW           = 17
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        dir,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [3:0]        rom_q,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [3:0]        fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2((SPR_W > SPR_H) ? SPR_W : SPR_H);

    state_t        state;
    logic [9:0]    pos_x_r;
    logic [9:0]    pos_y_r;
    logic [1:0]    dir_r;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic [CW-1:0] nx_dx;
    logic [CW-1:0] nx_dy;
    logic [10:0]   fx;
    logic [10:0]   fy;
    logic          last_px;
    logic          skip;
    logic          adv;

    sprite_addr_map #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .ROM_AW(ROM_AW),
        .CW    (CW)
    ) u_addr_map (
        .dx         (dx),
        .dy         (dy),
        .dir        (dir_r),
        .rom_address(rom_address)
    );

    always_comb begin
        fx      = {1'b0, pos_x_r} + 11'(dx);
        fy      = {1'b0, pos_y_r} + 11'(dy);
        skip    = (rom_q == TRANSPARENT_IDX) || (fx >= 11'(FB_W)) || (fy >= 11'(FB_H));
        last_px = (dx == CW'(SPR_W - 1)) && (dy == CW'(SPR_H - 1));
        if (dx == CW'(SPR_W - 1)) begin
            nx_dx = '0;
            nx_dy = dy + CW'(1);
        end else begin
            nx_dx = dx + CW'(1);
            nx_dy = dy;
        end
        adv = ((state == LATCH) && skip) || ((state == WRITE) && fb_ready);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pos_x_r <= '0;
            pos_y_r <= '0;
            dir_r   <= DIR_0;
            dx      <= '0;
            dy      <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pos_x_r <= pos_x;
                        pos_y_r <= pos_y;
                        dir_r   <= dir;
                        dx      <= '0;
                        dy      <= '0;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ:  state <= LATCH;
                LATCH: begin
                    if (!skip) begin
                        fb_we   <= 1'b1;
                        fb_data <= rom_q;
                        fb_addr <= FB_AW'(32'(fy) * FB_W + 32'(fx));
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (fb_ready) fb_we <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Advance is shared by the LATCH-skip and WRITE-accept exits and overrides the state chosen above.
            if (adv) begin
                dx <= nx_dx;
                dy <= nx_dy;
                if (last_px) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= READ;
                end
            end
        end
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer side of the sprite path: copies a SPR_W x SPR_H sprite of 4-bit palette indices from a sprite ROM into a frame-buffer RAM.
- The placement is (pos_x, pos_y) with optional 0/90/180/270 rotation.
- Transparent indices are skipped and off-screen pixels are clipped.
- The VGA sprite/palette reader later scans this frame buffer out; this block sits between the game logic (tank position/direction) and the frame-buffer write port.

Parameters:
- SPR_W, 36, sprite width in pixels
- SPR_H, 36, sprite height in pixels; must equal SPR_W when dir is 1 or 3
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- TRANSPARENT_IDX, 4'h0, palette index that is never written
- ROM_AW, 11, ROM address width (ceil(log2(SPR_W*SPR_H)))
- FB_AW, 17, frame-buffer address width (ceil(log2(FB_W*FB_H)))

Ports:
- vga_clk, in, 1, single clock, all logic on rising edge
- reset_n, in, 1, asynchronous active-low reset
- start, in, 1, request a blit; sampled only in IDLE
- pos_x, in, 10, destination top-left x, unsigned
- pos_y, in, 10, destination top-left y, unsigned
- dir, in, 2, rotation: 0 = none, 1 = 90 cw, 2 = 180, 3 = 270 cw
- rom_address, out, ROM_AW, sprite ROM read address
- rom_q, in, 4, ROM data; valid exactly one cycle after rom_address is presented
- fb_we, out, 1, frame-buffer write request
- fb_addr, out, FB_AW, frame-buffer write address
- fb_data, out, 4, palette index to write
- fb_ready, in, 1, write accepted on a cycle where fb_we && fb_ready
- busy, out, 1, high from start acceptance until done
- done, out, 1, one-cycle pulse when a blit completes

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE
  - rom_address=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0
  - destination counters dx, dy = 0
  - Reset mid-blit aborts immediately: no further writes and no done pulse.
- IDLE:
  - On start=1, latch pos_x, pos_y and dir; clear dx=dy=0; busy=1; go to READ.
  - start while busy is ignored.
- Source mapping for destination (dx,dy):
  - dir0: (dx, dy)
  - dir1: (dy, SPR_W-1-dx)
  - dir2: (SPR_W-1-dx, SPR_H-1-dy)
  - dir3: (SPR_H-1-dy, dx)
  - rom_address = sy*SPR_W + sx
- READ (1 cycle): drive rom_address for the current (dx,dy); go to LATCH.
- LATCH (1 cycle):
  - Compute fx = pos_x + dx and fy = pos_y + dy at 11-bit width, so there is no wrap.
  - If rom_q == TRANSPARENT_IDX, or fx >= FB_W, or fy >= FB_H: skip the pixel and ADVANCE.
  - Otherwise register fb_data = rom_q and fb_addr = fy*FB_W + fx (FB_AW bits), then go to WRITE.
- WRITE:
  - fb_we=1 with fb_addr and fb_data held stable until fb_ready=1.
  - On the accepting cycle, fb_we deasserts at the next edge, then ADVANCE.
  - fb_ready is ignored when fb_we=0.
- ADVANCE (folded into the LATCH/WRITE exit, no extra cycle):
  - dx increments; at SPR_W-1, dx wraps to 0 and dy increments.
  - If dx=SPR_W-1 and dy=SPR_H-1, go to DONE; otherwise go to READ.
- DONE (1 cycle): done=1, busy=0 at the next edge; return to IDLE. A start in DONE is ignored.
- Throughput:
  - skipped pixel = 2 cycles
  - written pixel = 3 cycles + stall cycles
  - Fully opaque, on-screen 36x36 sprite with fb_ready tied high: 3888 cycles from start acceptance to the done pulse (+1).
- Clipping is destination-only: pixels at negative positions cannot occur (unsigned pos), and partially off-right/bottom sprites are truncated.

Decomposition:
- Shared package sprite_pkg:
  - state enum typedef (IDLE, READ, LATCH, WRITE, DONE)
  - dir encoding constants (DIR_0, DIR_90, DIR_180, DIR_270)
  - TRANSPARENT_IDX default
  - FB_W/FB_H defaults shared with the frame-buffer reader
- One natural sub-module: sprite_addr_map, a combinational rotation plus rom_address computation from (dx, dy, dir).

Test Plan:
- All-transparent ROM, start at pos (10,10), dir0 -> zero fb_we cycles; done pulses exactly 2592 cycles after start acceptance.
- All-opaque ROM with index = (addr mod 15)+1, pos (0,0), dir0, fb_ready=1 -> 1296 writes; first fb_addr=0; write for dx=35, dy=0 at fb_addr=35; last fb_addr=35*320+35=11235; done at cycle 3889.
- Clip: opaque ROM, pos (300,220) -> exactly 20x20=400 writes; no fb_addr with x>=320 or y>=240.
- Rotation dir2, opaque ROM, pos (0,0) -> first write has fb_addr=0 and fb_data=ROM[1295]; last write fb_data=ROM[0] at fb_addr=11235.
- Backpressure: fb_ready low for 5 cycles on the first write -> fb_we, fb_addr and fb_data stable for 6 cycles; total write count unchanged.
- Reset low for 1 cycle after 100 writes, then start again -> outputs zero during reset; no done from the aborted blit; the second blit completes normally. A start pulsed during the blit is ignored, producing only one done.
